// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with one outstanding request and redirect handling
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pc_sel,
    input  logic [DATA_WIDTH-1:0] pc_target,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  discard_q, discard_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]           fetch_count_q, fetch_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC & ALIGN_MASK;
            discard_q     <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            discard_q     <= discard_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        discard_d     = discard_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d   = ST_WAIT;
                    discard_d = pc_sel;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    discard_d = 1'b0;
                    // A redirect seen now or earlier makes this response stale
                    if (discard_q || pc_sel) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_HOLD;
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc_q;
                    end
                end else if (pc_sel) begin
                    discard_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (pc_sel) begin
                    state_d = ST_REQ;
                end else if (instr_ready) begin
                    state_d       = ST_REQ;
                    pc_d          = pc_q + DATA_WIDTH'(4);
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (pc_sel) begin
            pc_d = pc_target & ALIGN_MASK;
        end
    end

    // Reset gating keeps the request low while rst_n is held even though the state is REQ
    assign imem_req_valid = rst_n && (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == ST_HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of PC, addresses, instruction data.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pc_sel  input  1  branch-unit redirect; 1 = take pc_target.
REQ-006 pc_target  input  DATA_WIDTH  redirect target address.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  DATA_WIDTH  fetch address, bits [1:0] always 0.
REQ-010 imem_rsp_valid  input  1  instruction data returned, one-cycle pulse per accepted request.
REQ-011 imem_rsp_data  input  DATA_WIDTH  returned instruction word.
REQ-012 instr_valid  output  1  held instruction available downstream.
REQ-013 instr_ready  input  1  downstream consumes instruction.
REQ-014 instr  output  DATA_WIDTH  held instruction.
REQ-015 instr_pc  output  DATA_WIDTH  address of held instruction.
REQ-016 fetch_count  output  32  count of instructions consumed downstream.

Function
REQ-017 States SHALL be REQ, WAIT, HOLD; at most one request outstanding.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT.
REQ-019 WAIT: imem_req_valid=0; on imem_rsp_valid with discard=0, register imem_rsp_data into instr, pc into instr_pc -> HOLD (instr_valid rises next cycle after response).
REQ-020 WAIT with discard=1: on imem_rsp_valid drop data, clear discard -> REQ.
REQ-021 HOLD: instr_valid=1, instr/instr_pc stable; on instr_ready: pc <= pc+4 (mod 2^DATA_WIDTH, wraps 32'hFFFF_FFFC -> 0), fetch_count +1 (wraps), -> REQ.
REQ-022 Redirect (pc_sel=1 at edge) SHALL set pc <= {pc_target[DATA_WIDTH-1:2],2'b00} in every state, overriding pc+4.
REQ-023 Redirect in REQ without imem_req_ready: stay REQ; new address presented next cycle (only case where address may change while valid).
REQ-024 Redirect in REQ with imem_req_ready same cycle: -> WAIT, discard=1.
REQ-025 Redirect in WAIT without imem_rsp_valid: stay WAIT, discard=1.
REQ-026 Redirect in WAIT with imem_rsp_valid same cycle: drop response, discard=0, -> REQ.
REQ-027 Redirect in HOLD: drop held instruction, instr_valid=0 next cycle, fetch_count unchanged even if instr_ready=1, -> REQ.
REQ-028 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-029 instr_valid SHALL never depend combinationally on instr_ready; all outputs registered or decoded from state only.

Reset
REQ-030 While rst_n=0: state=REQ, pc=RESET_PC, discard=0, instr=0, instr_pc=0, fetch_count=0, imem_req_valid=0, instr_valid=0.
REQ-031 First cycle after rst_n rises: imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-032 Reset asserted mid-WAIT SHALL abandon the outstanding request; a response arriving later in WAIT is accepted as the new fetch (memory is reset together).

Verification
REQ-033 Sequential fetch: ready=1, rsp one cycle after accept with 0x00000013, instr_ready=1 -> instr_pc 0x0,0x4,0x8; fetch_count=3.
REQ-034 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, no new request, fetch_count unchanged.
REQ-035 Redirect in HOLD: pc_sel=1, pc_target=0x0000_0103, instr_ready=1 -> held instr dropped, next imem_req_addr=0x0000_0100, fetch_count unchanged.
REQ-036 Redirect in WAIT: pc_sel=1, pc_target=0x200, response 0xDEADBEEF two cycles later -> dropped, next request addr 0x200, instr_valid stays 0.
REQ-037 Simultaneous accept+redirect in REQ: imem_req_ready=1, pc_sel=1, target 0x40 -> old response dropped, next request 0x40.
REQ-038 Wrap and reset: RESET_PC=0xFFFF_FFFC, consume one instr -> next addr 0x0; assert rst_n=0 mid-WAIT -> outputs per REQ-030 immediately.
